// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, functs, ALUOp codes and
// control-bundle layout used by ID, ID/EX and EX.
package decode_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ANDI  = 4'h2;
  localparam logic [3:0] OP_ORI   = 4'h3;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_SLT = 3'd4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;
  localparam int M_BRANCH      = 2;
  localparam int M_MEM_READ    = 1;
  localparam int M_MEM_WRITE   = 0;
  localparam int EX_REG_DST    = 5;
  localparam int EX_ALU_SRC    = 4;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [5:0] ex;
  } ctrl_t;

  function automatic logic [5:0] exBits(
    input logic regDst,
    input logic aluSrc,
    input logic [3:0] aluOp
  );
    return {regDst, aluSrc, aluOp};
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// 8-entry register file, r0 hardwired to zero, with
// write-through bypass so a same-cycle write is visible on reads.
module regfile_8x16 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        rdAddr1,
  input  logic [2:0]        rdAddr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  input  logic              wrEn,
  input  logic [2:0]        wrAddr,
  input  logic [DATA_W-1:0] wrData
);

  logic [DATA_W-1:0] regs [8];
  logic              wrLive;

  assign wrLive = wrEn && (wrAddr != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wrLive) begin
      regs[wrAddr] <= wrData;
    end
  end

  always_comb begin
    rdData1 = regs[rdAddr1];
    rdData2 = regs[rdAddr2];
    if (wrLive && wrAddr == rdAddr1) rdData1 = wrData;
    if (wrLive && wrAddr == rdAddr2) rdData2 = wrData;
    if (rdAddr1 == 3'd0) rdData1 = '0;
    if (rdAddr2 == 3'd0) rdData2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, register read with WB bypass, load-use
// hazard detection and a saturating stall-cycle counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic              idex_mem_read,
  input  logic [2:0]        idex_rt,
  input  logic              wb_reg_write,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [1:0]        wb_ctrl,
  output logic [2:0]        m_ctrl,
  output logic [5:0]        ex_ctrl,
  output logic [DATA_W-1:0] pc_plus4_out,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] imm_sext,
  output logic [2:0]        rt_out,
  output logic [2:0]        rd_out,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              illegal_instr,
  output logic [CNT_W-1:0]  stall_count
);

  logic [3:0]        opcode;
  logic [2:0]        rs, rt, rd, funct;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] rfData1, rfData2;
  logic [CNT_W-1:0]  stallCnt;
  ctrl_t             dec;
  logic              illegal, usesRt, stall, kill;

  assign opcode = instr[15:12];
  assign rs     = instr[11:9];
  assign rt     = instr[8:6];
  assign rd     = instr[5:3];
  assign funct  = instr[2:0];
  assign imm    = instr[IMM_W-1:0];

  regfile_8x16 #(.DATA_W(DATA_W)) uRegfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdAddr1 (rs),
    .rdAddr2 (rt),
    .rdData1 (rfData1),
    .rdData2 (rfData2),
    .wrEn    (wb_reg_write),
    .wrAddr  (wb_rd),
    .wrData  (wb_data)
  );

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      opcode == OP_RTYPE: begin
        dec.wb = 2'b10;
        unique case (funct)
          F_ADD:   dec.ex = exBits(1'b1, 1'b0, ALU_ADD);
          F_SUB:   dec.ex = exBits(1'b1, 1'b0, ALU_SUB);
          F_AND:   dec.ex = exBits(1'b1, 1'b0, ALU_AND);
          F_OR:    dec.ex = exBits(1'b1, 1'b0, ALU_OR);
          F_SLT:   dec.ex = exBits(1'b1, 1'b0, ALU_SLT);
          default: illegal = 1'b1;
        endcase
      end
      opcode == OP_ADDI: begin
        dec.wb = 2'b10;
        dec.ex = exBits(1'b0, 1'b1, ALU_ADD);
      end
      opcode == OP_ANDI: begin
        dec.wb = 2'b10;
        dec.ex = exBits(1'b0, 1'b1, ALU_AND);
      end
      opcode == OP_ORI: begin
        dec.wb = 2'b10;
        dec.ex = exBits(1'b0, 1'b1, ALU_OR);
      end
      opcode == OP_LW: begin
        dec.wb = 2'b11;
        dec.m[M_MEM_READ] = 1'b1;
        dec.ex = exBits(1'b0, 1'b1, ALU_ADD);
      end
      opcode == OP_SW: begin
        dec.m[M_MEM_WRITE] = 1'b1;
        dec.ex = exBits(1'b0, 1'b1, ALU_ADD);
      end
      opcode == OP_BEQ: begin
        dec.m[M_BRANCH] = 1'b1;
        dec.ex = exBits(1'b0, 1'b0, ALU_SUB);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign usesRt = (opcode == OP_RTYPE) ||
                  (opcode == OP_SW) ||
                  (opcode == OP_BEQ);

  assign stall = idex_mem_read && (idex_rt != 3'd0) &&
                 ((idex_rt == rs) || (usesRt && idex_rt == rt)) &&
                 !flush;

  // Illegal opcodes become bubbles like stalls and flushes.
  assign kill = stall || flush || illegal || !rst_n;

  assign wb_ctrl    = kill ? 2'b0 : dec.wb;
  assign m_ctrl     = kill ? 3'b0 : dec.m;
  assign ex_ctrl    = kill ? 6'b0 : dec.ex;
  assign pc_write   = rst_n && !stall;
  assign ifid_write = rst_n && !stall;

  assign illegal_instr = rst_n && illegal;
  assign pc_plus4_out  = rst_n ? pc_plus4 : '0;
  assign read_data1    = rst_n ? rfData1 : '0;
  assign read_data2    = rst_n ? rfData2 : '0;
  assign rt_out        = rst_n ? rt : 3'd0;
  assign rd_out        = rst_n ? rd : 3'd0;
  assign imm_sext      = rst_n ?
    {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stall && stallCnt != '1) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign stall_count = stallCnt;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed checks of decode_stage against a
// table-driven reference model of the decode rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr, pc_plus4;
  logic        idex_mem_read;
  logic [2:0]  idex_rt;
  logic        wb_reg_write;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flush;
  logic [1:0]  wb_ctrl;
  logic [2:0]  m_ctrl;
  logic [5:0]  ex_ctrl;
  logic [15:0] pc_plus4_out, read_data1, read_data2, imm_sext;
  logic [2:0]  rt_out, rd_out;
  logic        pc_write, ifid_write, illegal_instr;
  logic [15:0] stall_count;

  int nCmp = 0;
  int nBad = 0;
  logic [15:0] mRegs [8];
  int mCnt;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .pc_plus4      (pc_plus4),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .wb_ctrl       (wb_ctrl),
    .m_ctrl        (m_ctrl),
    .ex_ctrl       (ex_ctrl),
    .pc_plus4_out  (pc_plus4_out),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .imm_sext      (imm_sext),
    .rt_out        (rt_out),
    .rd_out        (rd_out),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .illegal_instr (illegal_instr),
    .stall_count   (stall_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // {illegal, wb[1:0], m[2:0], ex[5:0]}
  function automatic logic [11:0] refDecode(input logic [15:0] i);
    int op, fn;
    op = int'(i[15:12]);
    fn = int'(i[2:0]);
    case (op)
      0: return (fn <= 4) ? {1'b0, 2'b10, 3'b000, 2'b10, 4'(fn)}
                          : 12'h800;
      1: return {1'b0, 2'b10, 3'b000, 6'b010000};
      2: return {1'b0, 2'b10, 3'b000, 6'b010010};
      3: return {1'b0, 2'b10, 3'b000, 6'b010011};
      4: return {1'b0, 2'b11, 3'b010, 6'b010000};
      5: return {1'b0, 2'b00, 3'b001, 6'b010000};
      6: return {1'b0, 2'b00, 3'b100, 6'b000001};
      default: return 12'h800;
    endcase
  endfunction

  function automatic bit refStall();
    int op;
    bit rtUsed;
    op = int'(instr[15:12]);
    rtUsed = (op == 0) || (op == 5) || (op == 6);
    return idex_mem_read && idex_rt != 0 && !flush &&
           (idex_rt == instr[11:9] ||
            (rtUsed && idex_rt == instr[8:6]));
  endfunction

  function automatic logic [15:0] refRead(input logic [2:0] a);
    if (a == 0) return 16'h0;
    if (wb_reg_write && wb_rd != 0 && wb_rd == a) return wb_data;
    return mRegs[a];
  endfunction

  task automatic checkAll(input string tag);
    logic [11:0] d;
    bit st, bub;
    d = refDecode(instr);
    st = refStall();
    bub = st || flush || d[11];
    check({tag, ".wb"}, 32'(wb_ctrl), bub ? 0 : 32'(d[10:9]));
    check({tag, ".m"}, 32'(m_ctrl), bub ? 0 : 32'(d[8:6]));
    check({tag, ".ex"}, 32'(ex_ctrl), bub ? 0 : 32'(d[5:0]));
    check({tag, ".ill"}, 32'(illegal_instr), 32'(d[11]));
    check({tag, ".rd1"}, 32'(read_data1), 32'(refRead(instr[11:9])));
    check({tag, ".rd2"}, 32'(read_data2), 32'(refRead(instr[8:6])));
    check({tag, ".imm"}, 32'(imm_sext),
          32'($signed(16'(int'($signed(instr[5:0]))))) & 32'hFFFF);
    check({tag, ".pc"}, 32'(pc_plus4_out), 32'(pc_plus4));
    check({tag, ".rt"}, 32'(rt_out), 32'(instr[8:6]));
    check({tag, ".rdo"}, 32'(rd_out), 32'(instr[5:3]));
    check({tag, ".pcw"}, 32'(pc_write), st ? 0 : 1);
    check({tag, ".ifw"}, 32'(ifid_write), st ? 0 : 1);
    check({tag, ".cnt"}, 32'(stall_count), 32'(mCnt));
  endtask

  task automatic commit();
    if (refStall() && mCnt < 65535) mCnt++;
    if (wb_reg_write && wb_rd != 0) mRegs[wb_rd] = wb_data;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    checkAll(tag);
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic checkZero(input string tag);
    check({tag, ".wb"}, 32'(wb_ctrl), 0);
    check({tag, ".m"}, 32'(m_ctrl), 0);
    check({tag, ".ex"}, 32'(ex_ctrl), 0);
    check({tag, ".ill"}, 32'(illegal_instr), 0);
    check({tag, ".rd1"}, 32'(read_data1), 0);
    check({tag, ".rd2"}, 32'(read_data2), 0);
    check({tag, ".imm"}, 32'(imm_sext), 0);
    check({tag, ".pc"}, 32'(pc_plus4_out), 0);
    check({tag, ".rt"}, 32'(rt_out), 0);
    check({tag, ".rdo"}, 32'(rd_out), 0);
    check({tag, ".pcw"}, 32'(pc_write), 0);
    check({tag, ".ifw"}, 32'(ifid_write), 0);
    check({tag, ".cnt"}, 32'(stall_count), 0);
  endtask

  function automatic logic [15:0] mk(input int op, input int s,
                                     input int t, input int d,
                                     input int f);
    return {4'(op), 3'(s), 3'(t), 3'(d), 3'(f)};
  endfunction

  task automatic quiet();
    idex_mem_read = 0;
    idex_rt = 0;
    wb_reg_write = 0;
    wb_rd = 0;
    wb_data = 0;
    flush = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mRegs[i] = 16'h0;
    mCnt = 0;
    rst_n = 0;
    quiet();
    instr = mk(4, 3, 2, 1, 7);
    pc_plus4 = 16'h0104;
    wb_reg_write = 1;
    wb_rd = 3;
    wb_data = 16'h5555;
    #12;
    checkZero("rst");
    @(posedge clk);
    #1;
    checkZero("rst2");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    quiet();
    instr = mk(0, 0, 0, 0, 0);
    wb_reg_write = 1;
    wb_rd = 3;
    wb_data = 16'h1234;
    step("wr3");
    quiet();
    instr = mk(0, 3, 0, 1, 0);
    step("add");
    check("add.rd1v", 32'(read_data1), 32'h1234);

    wb_reg_write = 1;
    wb_rd = 5;
    wb_data = 16'hBEEF;
    instr = mk(0, 5, 3, 2, 1);
    @(negedge clk);
    check("byp.rd1v", 32'(read_data1), 32'hBEEF);
    checkAll("byp");
    commit();
    @(posedge clk);
    #1;

    wb_rd = 0;
    wb_data = 16'hFFFF;
    instr = mk(0, 0, 0, 4, 2);
    step("wr0");
    quiet();
    instr = mk(0, 0, 5, 4, 3);
    step("rd0");
    check("rd0.v", 32'(read_data1), 0);

    idex_mem_read = 1;
    idex_rt = 2;
    instr = mk(0, 4, 2, 7, 1);
    step("haz1");
    check("haz1.cntv", 32'(stall_count), 1);
    flush = 1;
    step("flush");
    flush = 0;
    quiet();
    instr = {4'h1, 3'd2, 3'd3, 6'b111110};
    step("addi");
    check("addi.immv", 32'(imm_sext), 32'hFFFE);
    instr = mk(10, 1, 2, 3, 4);
    step("op10");
    instr = mk(0, 1, 2, 3, 6);
    step("fn6");
    idex_mem_read = 1;
    idex_rt = 3;
    instr = {4'h1, 3'd1, 3'd3, 6'h05};
    step("addiRt");

    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom)
                                      : 4'($urandom_range(0, 6));
      instr = {op, 12'($urandom)};
      pc_plus4 = 16'($urandom);
      idex_mem_read = 1'($urandom);
      idex_rt = 3'($urandom);
      wb_reg_write = 1'($urandom);
      wb_rd = 3'($urandom);
      wb_data = 16'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      step($sformatf("rnd%0d", n));
    end

    quiet();
    idex_mem_read = 1;
    idex_rt = 6;
    instr = mk(6, 1, 6, 0, 0);
    repeat (70000) @(posedge clk);
    mCnt = (mCnt + 70000 > 65535) ? 65535 : mCnt + 70000;
    #1;
    step("sat");
    check("sat.cntv", 32'(stall_count), 32'hFFFF);

    wb_reg_write = 1;
    wb_rd = 4;
    wb_data = 16'hAAAA;
    #2;
    rst_n = 0;
    #1;
    checkZero("midrst");
    for (int i = 0; i < 8; i++) mRegs[i] = 16'h0;
    mCnt = 0;
    @(negedge clk);
    rst_n = 1;
    quiet();
    @(posedge clk);
    #1;
    instr = mk(0, 3, 4, 1, 0);
    step("post");
    instr = mk(0, 5, 2, 1, 0);
    step("post2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
